// File: rtl/dmg_timer.sv
// DMG timer: 16-bit divider, TIMA/TMA/TAC, delayed overflow reload, falling-edge increment glitches.
// Latency: writes and increments visible 1 edge later; reload and irq land 4 edges after overflow.
// Backpressure: none; every strobe is accepted on the edge it is high.
module dmg_timer #(
    parameter logic [15:0] INITIAL_DIV = 'x
) (
    input  logic       dffrc_clk,
    input  logic       nreset,
    input  logic       div_wr,
    input  logic       tima_wr,
    input  logic       tma_wr,
    input  logic       tac_wr,
    input  logic [7:0] wdata,
    output logic [7:0] div_q,
    output logic [7:0] tima_q,
    output logic [7:0] tma_q,
    output logic [2:0] tac_q,
    output logic       timer_irq
);
    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_PEND   = 1'b1;

    logic [15:0] divider;
    logic [15:0] div_next;
    logic [7:0]  tima;
    logic [7:0]  tima_inc;
    logic [7:0]  tma;
    logic [7:0]  tma_next;
    logic [2:0]  tac;
    logic [0:0]  state;
    logic [1:0]  ovf_cnt;
    logic        tap_bit;
    logic        s;
    logic        s_prev;
    logic        inc_evt;

    assign div_next = div_wr ? 16'h0000 : divider + 16'd1;

    generate
        if ($isunknown(INITIAL_DIV)) begin : g_div_noinit
            logic [15:0] div_r;

            always_ff @(posedge dffrc_clk or negedge nreset) begin
                if (!nreset) begin
                    div_r <= 16'h0000;
                end else begin
                    div_r <= div_next;
                end
            end

            assign divider = div_r;
        end else begin : g_div_init
            // A known power-on value is only meaningful where flops support an init value.
            logic [15:0] div_r = INITIAL_DIV;

            always_ff @(posedge dffrc_clk or negedge nreset) begin
                if (!nreset) begin
                    div_r <= 16'h0000;
                end else begin
                    div_r <= div_next;
                end
            end

            assign divider = div_r;
        end
    endgenerate

    always_comb begin
        tap_bit = 1'b0;
        unique case (tac[1:0])
            2'b00: tap_bit = divider[9];
            2'b01: tap_bit = divider[3];
            2'b10: tap_bit = divider[5];
            2'b11: tap_bit = divider[7];
        endcase
    end

    // Any falling edge of the gated tap counts, whatever caused it.
    assign s        = tac[2] & tap_bit;
    assign inc_evt  = s_prev & ~s;
    assign tima_inc = tima + 8'd1;
    assign tma_next = tma_wr ? wdata : tma;

    always_ff @(posedge dffrc_clk or negedge nreset) begin
        if (!nreset) begin
            s_prev <= 1'b0;
            tma    <= 8'h00;
            tac    <= 3'b000;
        end else begin
            s_prev <= s;
            tma    <= tma_next;
            if (tac_wr) begin
                tac <= wdata[2:0];
            end
        end
    end

    always_ff @(posedge dffrc_clk or negedge nreset) begin
        if (!nreset) begin
            tima      <= 8'h00;
            state     <= ST_NORMAL;
            ovf_cnt   <= 2'd0;
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= 1'b0;
            unique case (state)
                ST_NORMAL: begin
                    if (tima_wr) begin
                        tima <= wdata;
                    end else if (inc_evt) begin
                        tima <= tima_inc;
                        if (tima == 8'hFF) begin
                            ovf_cnt <= 2'd3;
                            state   <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (ovf_cnt != 2'd0) begin
                        ovf_cnt <= ovf_cnt - 2'd1;
                        if (tima_wr) begin
                            // Writing TIMA during the delay window cancels the reload and irq.
                            tima    <= wdata;
                            ovf_cnt <= 2'd0;
                            state   <= ST_NORMAL;
                        end else if (inc_evt) begin
                            tima <= tima_inc;
                        end
                    end else begin
                        tima      <= tma_next;
                        timer_irq <= 1'b1;
                        state     <= ST_NORMAL;
                    end
                end
            endcase
        end
    end

    assign div_q  = divider[15:8];
    assign tima_q = tima;
    assign tma_q  = tma;
    assign tac_q  = tac;

endmodule

// File: tb/tb_dmg_timer.sv
// Bench for dmg_timer: directed scripts with literal expectations plus a randomized run
// checked every cycle against an edge-scheduled behavioural model.
module tb_dmg_timer;

    logic       dffrc_clk = 1'b0;
    logic       nreset    = 1'b0;
    logic       div_wr    = 1'b0;
    logic       tima_wr   = 1'b0;
    logic       tma_wr    = 1'b0;
    logic       tac_wr    = 1'b0;
    logic [7:0] wdata     = 8'h00;
    logic [7:0] div_q;
    logic [7:0] tima_q;
    logic [7:0] tma_q;
    logic [2:0] tac_q;
    logic       timer_irq;

    int checks   = 0;
    int failures = 0;

    dmg_timer dut (
        .dffrc_clk (dffrc_clk),
        .nreset    (nreset),
        .div_wr    (div_wr),
        .tima_wr   (tima_wr),
        .tma_wr    (tma_wr),
        .tac_wr    (tac_wr),
        .wdata     (wdata),
        .div_q     (div_q),
        .tima_q    (tima_q),
        .tma_q     (tma_q),
        .tac_q     (tac_q),
        .timer_irq (timer_irq)
    );

    always #5 dffrc_clk = ~dffrc_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: overflow schedules the reload for a fixed absolute edge number.
    int tap_tbl[4] = '{9, 3, 5, 7};
    int m_div, m_tima, m_tma, m_tac, m_irq;
    int m_reload_edge;
    int edge_no = 0;
    bit m_prev_s;

    task automatic m_reset();
        m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_irq = 0;
        m_prev_s = 1'b0;
        m_reload_edge = -1;
    endtask

    always @(posedge dffrc_clk or negedge nreset) begin
        if (!nreset) begin
            m_reset();
        end else begin
            int tap, tma_nx;
            bit s, evt;
            tap    = tap_tbl[m_tac & 3];
            s      = (((m_tac >> 2) & 1) != 0) && (((m_div >> tap) & 1) != 0);
            evt    = m_prev_s && !s;
            tma_nx = tma_wr ? int'(wdata) : m_tma;
            m_irq  = 0;
            if (m_reload_edge == edge_no) begin
                m_tima = tma_nx;
                m_irq = 1;
                m_reload_edge = -1;
            end else if (m_reload_edge > edge_no) begin
                if (tima_wr) begin
                    m_tima = int'(wdata);
                    m_reload_edge = -1;
                end else if (evt) begin
                    m_tima = (m_tima + 1) % 256;
                end
            end else if (tima_wr) begin
                m_tima = int'(wdata);
            end else if (evt) begin
                if (m_tima == 255) begin
                    m_tima = 0;
                    m_reload_edge = edge_no + 4;
                end else begin
                    m_tima = m_tima + 1;
                end
            end
            m_tma = tma_nx;
            if (tac_wr) m_tac = int'(wdata) & 7;
            m_div = div_wr ? 0 : (m_div + 1) % 65536;
            m_prev_s = s;
        end
        edge_no++;
    end

    always @(posedge dffrc_clk) begin
        #2;
        chk("cmp_div_q", int'(div_q), (m_div >> 8) & 255);
        chk("cmp_tima", int'(tima_q), m_tima);
        chk("cmp_tma", int'(tma_q), m_tma);
        chk("cmp_tac", int'(tac_q), m_tac);
        chk("cmp_irq", int'(timer_irq), m_irq);
    end

    // Script: up to 4 writes, kind bits {div, tima, tma, tac}.
    localparam logic [3:0] K_DIV  = 4'b1000;
    localparam logic [3:0] K_TIMA = 4'b0100;
    localparam logic [3:0] K_TMA  = 4'b0010;
    localparam logic [3:0] K_TAC  = 4'b0001;

    int         sc_edge [4];
    logic [3:0] sc_kind [4];
    logic [7:0] sc_dat  [4];
    int tima_a [300];
    int irq_a  [300];
    int tma_a  [300];
    int div_a  [300];

    task automatic idle();
        div_wr = 0; tima_wr = 0; tma_wr = 0; tac_wr = 0; wdata = 8'h00;
    endtask

    task automatic set_w(input int idx, input int e, input logic [3:0] k, input logic [7:0] d);
        sc_edge[idx] = e; sc_kind[idx] = k; sc_dat[idx] = d;
    endtask

    task automatic base_ovf();
        set_w(0, 1, K_TAC, 8'h05);
        set_w(1, 2, K_TMA, 8'hAB);
        set_w(2, 3, K_TIMA, 8'hFF);
        set_w(3, -1, 4'b0000, 8'h00);
    endtask

    task automatic do_reset();
        idle();
        nreset = 1'b0;
        repeat (2) @(negedge dffrc_clk);
        nreset = 1'b1;
    endtask

    task automatic run_script(input int last);
        do_reset();
        for (int e = 1; e <= last; e++) begin
            idle();
            for (int k = 0; k < 4; k++) begin
                if (sc_edge[k] == e) begin
                    {div_wr, tima_wr, tma_wr, tac_wr} = sc_kind[k];
                    wdata = sc_dat[k];
                end
            end
            @(negedge dffrc_clk);
            tima_a[e] = int'(tima_q);
            irq_a[e]  = int'(timer_irq);
            tma_a[e]  = int'(tma_q);
            div_a[e]  = int'(div_q);
        end
        idle();
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_div", int'(div_q), 0);
        chk("rst_tima", int'(tima_q), 0);
        chk("rst_tma", int'(tma_q), 0);
        chk("rst_tac", int'(tac_q), 0);
        chk("rst_irq", int'(timer_irq), 0);

        // Basic counting with tap bit 3
        set_w(0, 1, K_TAC, 8'h05);
        set_w(1, -1, 4'b0000, 8'h00);
        set_w(2, -1, 4'b0000, 8'h00);
        set_w(3, -1, 4'b0000, 8'h00);
        run_script(256);
        chk("count_e16", tima_a[16], 0);
        for (int m = 1; m <= 15; m++) begin
            chk("count_step", tima_a[16 * m + 1], m);
            chk("count_hold", tima_a[16 * m + 16], m);
        end
        chk("div_e255", div_a[255], 0);
        chk("div_e256", div_a[256], 1);

        // Overflow reload: overflow on edge 17
        base_ovf();
        run_script(24);
        for (int e = 17; e <= 20; e++) chk("ovf_zero", tima_a[e], 0);
        chk("ovf_reload", tima_a[21], 8'hAB);
        chk("ovf_irq_before", irq_a[20], 0);
        chk("ovf_irq", irq_a[21], 1);
        chk("ovf_irq_after", irq_a[22], 0);

        // Cancel on n+2
        base_ovf();
        set_w(3, 19, K_TIMA, 8'h42);
        run_script(24);
        for (int e = 19; e <= 24; e++) begin
            chk("cancel_tima", tima_a[e], 8'h42);
            chk("cancel_irq", irq_a[e], 0);
        end

        // TIMA write on the reload edge is ignored
        base_ovf();
        set_w(3, 21, K_TIMA, 8'h42);
        run_script(23);
        chk("rl_tima_wr_tima", tima_a[21], 8'hAB);
        chk("rl_tima_wr_irq", irq_a[21], 1);

        // TMA write on the reload edge is forwarded
        base_ovf();
        set_w(3, 21, K_TMA, 8'h33);
        run_script(23);
        chk("rl_tma_wr_tima", tima_a[21], 8'h33);
        chk("rl_tma_wr_tma", tma_a[21], 8'h33);
        chk("rl_tma_wr_irq", irq_a[21], 1);

        // Glitch: div_wr while bit 3 high
        set_w(0, 1, K_TAC, 8'h05);
        set_w(1, 9, K_DIV, 8'h00);
        set_w(2, -1, 4'b0000, 8'h00);
        set_w(3, -1, 4'b0000, 8'h00);
        run_script(12);
        chk("glitch_div_e9", tima_a[9], 0);
        chk("glitch_div_e10", tima_a[10], 1);

        // No glitch: div_wr with tap bit 9 low
        set_w(0, 1, K_TAC, 8'h04);
        set_w(1, 257, K_DIV, 8'h00);
        run_script(262);
        chk("noglitch_e257", tima_a[257], 0);
        chk("noglitch_e262", tima_a[262], 0);

        // Glitch: TAC disable while bit 3 high
        set_w(0, 1, K_TAC, 8'h05);
        set_w(1, 9, K_TAC, 8'h01);
        run_script(12);
        chk("glitch_tac_e9", tima_a[9], 0);
        chk("glitch_tac_e10", tima_a[10], 1);

        // Async reset between n+1 and n+2
        base_ovf();
        run_script(18);
        #2 nreset = 1'b0;
        #1;
        chk("arst_div", int'(div_q), 0);
        chk("arst_tima", int'(tima_q), 0);
        chk("arst_tma", int'(tma_q), 0);
        chk("arst_tac", int'(tac_q), 0);
        chk("arst_irq", int'(timer_irq), 0);
        @(negedge dffrc_clk);
        @(negedge dffrc_clk);
        nreset = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(negedge dffrc_clk);
            chk("arst_post_tima", int'(tima_q), 0);
            chk("arst_post_irq", int'(timer_irq), 0);
        end

        // Randomized run against the model
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            idle();
            wdata = 8'($urandom);
            if ($urandom_range(0, 63) == 0) div_wr = 1'b1;
            if ($urandom_range(0, 23) == 0) begin
                tima_wr = 1'b1;
                case ($urandom_range(0, 3))
                    0: wdata = 8'hFF;
                    1: wdata = 8'hFE;
                    default: ;
                endcase
            end
            if ($urandom_range(0, 31) == 0) tma_wr = 1'b1;
            if ($urandom_range(0, 47) == 0) begin
                tac_wr = 1'b1;
                if ($urandom_range(0, 1) == 0) wdata = 8'h05;
            end
            if ($urandom_range(0, 499) == 0) begin
                #3 nreset = 1'b0;
                @(negedge dffrc_clk);
                @(negedge dffrc_clk);
                nreset = 1'b1;
            end else begin
                @(negedge dffrc_clk);
            end
        end
        idle();
        @(negedge dffrc_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmg_timer.md
# dmg_timer

Game Boy DMG timer block: 16-bit free-running divider (DIV), timer counter TIMA, modulo register TMA, control register TAC, with DMG-exact overflow-reload delay and falling-edge increment glitches. Sits directly downstream of the flip-flop cell layer, clocked by the same `dffrc_clk` domain at 4 MiHz. Feeds the interrupt controller (timer request) and the CPU read mux (register values).

## Interface
- `INITIAL_DIV`, default `'x`: power-on value of the 16-bit divider before the first reset. `'x` means a random value.
- `dffrc_clk  input  1`: clock. All state updates on the rising edge.
- `nreset  input  1`: reset, asynchronous, active-low.
- `div_wr  input  1`: write strobe for FF04. Data is ignored.
- `tima_wr  input  1`: write strobe for FF05.
- `tma_wr  input  1`: write strobe for FF06.
- `tac_wr  input  1`: write strobe for FF07. Only `wdata[2:0]` is stored.
- `wdata  input  8`: write data, sampled on the edge where a strobe is high.
- `div_q  output  8`: divider bits [15:8].
- `tima_q  output  8`: TIMA.
- `tma_q  output  8`: TMA.
- `tac_q  output  3`: TAC[2:0].
- `timer_irq  output  1`: timer interrupt request pulse.

## Operation
- Reset (`nreset` low): divider=0x0000, TIMA=0, TMA=0, TAC=0, `timer_irq`=0, `s_prev`=0, state NORMAL, ovf_cnt=0. All outputs read 0. Reset takes effect immediately and is held while low.
- **Divider**
  - Increments by 1 every edge and wraps 0xFFFF→0x0000.
  - `div_wr` clears the divider to 0x0000 on that edge. The write takes priority over the increment.
- **Tap select**
  - TAC[1:0]: 00→bit 9, 01→bit 3, 10→bit 5, 11→bit 7.
  - `s` = TAC[2] & divider[tap], combinational from current register values.
  - `s_prev` registers `s` every edge.
- **Increment event**
  - Occurs on an edge where `s_prev`=1 and `s`=0.
  - The cause can be a natural divider carry, a `div_wr` clear, a TAC disable, or a tap change; all are treated the same.
  - The event increments TIMA by 1, modulo 256.
- **States**
  - **NORMAL**
    - Increment event with TIMA=0xFF: TIMA←0x00, ovf_cnt←3, go to PEND.
    - `tima_wr`: TIMA←wdata. A write wins over a same-edge increment.
  - **PEND**
    - Each edge with ovf_cnt>0 decrements ovf_cnt.
    - Increment events still modify TIMA.
    - `tima_wr` while ovf_cnt>0: TIMA←wdata, go to NORMAL. The reload and IRQ are cancelled.
    - Edge with ovf_cnt=0 is the RELOAD edge:
      - TIMA←TMA_next, where TMA_next = wdata if `tma_wr`, else TMA.
      - `tima_wr` on this edge is ignored.
      - `timer_irq`←1; go to NORMAL.
- `timer_irq` is registered. It is high for exactly one clock after the RELOAD edge and 0 otherwise.
- TMA and TAC writes take effect on their edge in every state.

## Timing
- Register writes are visible on outputs after the write edge. Latency is 1 edge.
- Increment latency: TIMA changes 1 edge after the edge on which `s` falls, because `s_prev` compares against it.
- Overflow: TIMA reads 0x00 after overflow edge n and stays there (absent further events) through edge n+3. It reads TMA and `timer_irq`=1 after edge n+4.
- Tap period with TAC enabled: 1024 / 16 / 64 / 256 edges for TAC[1:0] = 00 / 01 / 10 / 11.
- `nreset` asserted mid-PEND: no reload and no IRQ after release.

## Test plan
- **Basic counting**
  - Stimulus: reset, then `tac_wr` 0x05 on edge 1; divider counts from 0.
  - Required: TIMA=0x01 after edge 17, 0x02 after edge 33, and increments every 16 edges thereafter; `div_q`=0x01 after edge 256.
- **Overflow reload**
  - Stimulus: TMA=0xAB, TIMA=0xFF; overflow on edge n.
  - Required: TIMA=0x00 after edges n..n+3; TIMA=0xAB after edge n+4; `timer_irq`=1 for exactly that one clock.
- **Cancel**
  - Stimulus: as the overflow case, plus `tima_wr` 0x42 on edge n+2.
  - Required: TIMA=0x42 from n+2 onward; no reload; `timer_irq` stays 0.
- **Writes on the RELOAD edge**
  - Stimulus: `tima_wr` 0x42 on edge n+4.
  - Required: TIMA=0xAB and IRQ fires.
  - Stimulus, separate run: `tma_wr` 0x33 on edge n+4.
  - Required: TIMA=0x33, `tma_q`=0x33, and IRQ fires.
- **Glitch increments**
  - Stimulus: TAC=0x05, divider=0x0008, `div_wr`.
  - Required: TIMA+1 on the next edge.
  - Stimulus: TAC=0x04, divider=0x0100, `div_wr`.
  - Required: no increment.
  - Stimulus: TAC=0x05, divider bit 3=1, `tac_wr` 0x01.
  - Required: TIMA+1.
- **Async reset**
  - Stimulus: drop `nreset` between edges n+1 and n+2 of an overflow.
  - Required: all outputs 0 immediately; after release, no IRQ and TIMA=0x00.
